// File: rtl/data_sram_bridge.sv
// data_sram_bridge: single-outstanding core-to-SRAM-bus request bridge.
// Latches one request from the core, runs an address/data handshake on the
// bus, and returns load data. If the bus stays silent too long the request is
// aborted with a one-cycle error flag.
module data_sram_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clka,
  input  logic                rst,
  // core side
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wmask,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_err,
  // bus side
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                wr_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic cnt_last;
  logic capture;
  logic timeout;
  logic accept;

  assign accept   = (state_q == IDLE) && cpu_en;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state: a completing handshake always beats the timeout. In ADDR an
  // address-only accept on the last allowed cycle still times out, so the
  // whole ADDR+DATA window never exceeds TIMEOUT cycles.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (cpu_en) state_d = ADDR;
      ADDR: begin
        if (bus_addr_ok && bus_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (cnt_last) begin
          state_d = DONE;
          timeout = 1'b1;
        end else if (bus_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (cnt_last) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request latch: held stable for the whole transfer.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= cpu_addr;
      wstrb_q <= cpu_wmask;
      wdata_q <= cpu_wdata;
      wr_q    <= |cpu_wmask;
    end
  end

  // Timeout counter: zeroed when a request is accepted, counts ADDR/DATA cycles.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                                      cnt_q <= '0;
    else if (accept)                               cnt_q <= '0;
    else if (state_q == ADDR || state_q == DATA)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // Load data register: zeroed on abort, updated only by completing reads.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                  rdata_q <= '0;
    else if (timeout)          rdata_q <= '0;
    else if (capture && !wr_q) rdata_q <= bus_rdata;
  end

  // Error flag: set on the edge into DONE by a timeout, so it covers DONE only.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= timeout;
  end

  assign bus_req   = (state_q == ADDR);
  assign bus_wr    = wr_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign cpu_stall = accept || (state_q == ADDR) || (state_q == DATA);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed scenarios plus randomized transactions
// checked against a per-transaction arithmetic model of the handshake rules.
module tb_data_sram_bridge;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clka = 1'b0;
  logic              rst;
  logic              cpu_en;
  logic [3:0]        cpu_wmask;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              cpu_err;
  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] mdl_rdata = '0;

  data_sram_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clka(clka), .rst(rst),
    .cpu_en(cpu_en), .cpu_wmask(cpu_wmask), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  // One transaction starting in IDLE. a = ADDR/DATA cycle index of addr_ok,
  // dok = per-cycle data_ok pattern (pulses before addr_ok must be ignored).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wmask,
                         input logic [31:0] wdata, input int a,
                         input logic [31:0] dok, input logic [31:0] rd_fixed,
                         input bit use_fixed);
    int comp;
    int last;
    int stalls;
    bit to;
    logic [31:0] cap;
    comp = -1;
    cap  = '0;
    for (int i = 0; i < TIMEOUT; i++)
      if (comp < 0 && dok[i] && i >= a) comp = i;
    to   = (comp < 0);
    last = to ? TIMEOUT - 1 : comp;
    stalls = 0;

    cpu_en = 1'b1; cpu_addr = addr; cpu_wmask = wmask; cpu_wdata = wdata;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    check("idle_req", bus_req, 1'b0);
    if (cpu_stall) stalls++;

    for (int i = 0; i <= last; i++) begin
      cyc();
      cpu_en = 1'b0; cpu_addr = $urandom; cpu_wmask = 4'($urandom); cpu_wdata = $urandom;
      bus_addr_ok = (i == a);
      bus_data_ok = dok[i];
      bus_rdata   = use_fixed ? rd_fixed : $urandom;
      if (i == last && !to) cap = bus_rdata;
      #1;
      if (cpu_stall) stalls++;
      check("busy_stall", cpu_stall, 1'b1);
      check("bus_req", bus_req, (i <= a));
      if (i <= a) begin
        check("bus_addr", bus_addr, addr);
        check("bus_wstrb", bus_wstrb, wmask);
        check("bus_wdata", bus_wdata, wdata);
        check("bus_wr", bus_wr, |wmask);
      end
    end

    if (to)              mdl_rdata = '0;
    else if (wmask == 0) mdl_rdata = cap;

    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'($urandom); bus_rdata = $urandom;
    #1;
    if (cpu_stall) stalls++;
    check("done_stall", cpu_stall, 1'b0);
    check("done_err", cpu_err, to);
    check("done_rdata", cpu_rdata, mdl_rdata);
    check("done_req", bus_req, 1'b0);
    check("stall_len", stalls, last + 2);

    cyc();
    bus_data_ok = 1'b0;
    #1;
    check("post_err", cpu_err, 1'b0);
    check("post_rdata", cpu_rdata, mdl_rdata);
  endtask

  initial begin
    int a;
    logic [31:0] dok;
    logic [3:0]  wm;

    rst = 1'b0; cpu_en = 1'b0; cpu_wmask = '0; cpu_addr = '0; cpu_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    #1;
    check("rst_req", bus_req, 1'b0);
    check("rst_wr", bus_wr, 1'b0);
    check("rst_err", cpu_err, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_stall", cpu_stall, 1'b0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Fastest read: both handshakes in first ADDR cycle.
    run_txn(32'h100, 4'b0000, 32'h0, 0, 32'h1, 32'hDEADBEEF, 1'b1);
    // Write: addr_ok first ADDR cycle, data_ok two cycles later; rdata untouched.
    run_txn(32'h104, 4'b0011, 32'h12345678, 0, 32'h4, 32'h55AA55AA, 1'b1);
    // No bus response at all: timeout.
    run_txn(32'h108, 4'b0000, 32'h0, TIMEOUT + 4, 32'h0, 32'h0, 1'b0);
    // Address accepted, data never arrives: timeout from DATA.
    run_txn(32'h10C, 4'b0000, 32'h0, 0, 32'h0, 32'h0, 1'b0);
    // data_ok exactly on the last allowed cycle wins over the timeout.
    run_txn(32'h110, 4'b0000, 32'h0, 0, 32'h1 << (TIMEOUT - 1), 32'hA5A5F00D, 1'b1);
    // data_ok before addr_ok must be ignored.
    run_txn(32'h114, 4'b0000, 32'h0, 3, 32'h23, 32'h0, 1'b0);
    // Back-to-back reads, no idle cycle between them.
    run_txn(32'h200, 4'b0000, 32'h0, 1, 32'h4, 32'h11111111, 1'b1);
    run_txn(32'h204, 4'b0000, 32'h0, 0, 32'h1, 32'h22222222, 1'b1);

    // Reset in the middle of DATA.
    run_txn(32'h300, 4'b0000, 32'h0, 0, 32'h1, 32'hCAFEF00D, 1'b1);
    cpu_en = 1'b1; cpu_addr = 32'h304; cpu_wmask = 4'b0000;
    #1;
    cyc();
    cpu_en = 1'b0; bus_addr_ok = 1'b1;
    #1;
    cyc();
    bus_addr_ok = 1'b0;
    #1;
    check("data_stall", cpu_stall, 1'b1);
    check("data_rdata_held", cpu_rdata, 32'hCAFEF00D);
    #1;
    rst = 1'b0;
    #1;
    mdl_rdata = '0;
    check("arst_rdata", cpu_rdata, 32'h0);
    check("arst_stall", cpu_stall, 1'b0);
    check("arst_req", bus_req, 1'b0);

    // Reset in the middle of ADDR: bus_req must drop immediately.
    cyc();
    rst = 1'b1;
    cpu_en = 1'b1; cpu_addr = 32'h308; cpu_wmask = 4'b1111; cpu_wdata = 32'h0BADC0DE;
    #1;
    cyc();
    cpu_en = 1'b0;
    #1;
    check("addr_req", bus_req, 1'b1);
    check("addr_wr", bus_wr, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_req_addr", bus_req, 1'b0);
    check("arst_wr_addr", bus_wr, 1'b0);

    // Late responses after release must not wake the FSM.
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = $urandom;
      #1;
      check("late_req", bus_req, 1'b0);
      check("late_stall", cpu_stall, 1'b0);
      check("late_rdata", cpu_rdata, 32'h0);
      cyc();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Randomized transactions with occasional idle gaps.
    for (int t = 0; t < 30; t++) begin
      a   = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 4));
      dok = $urandom & $urandom & $urandom;
      if (a < TIMEOUT && $urandom_range(0, 3) != 0) dok[a + int'($urandom_range(0, 3))] = 1'b1;
      wm  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_txn($urandom, wm, $urandom, a, dok, 32'h0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        cpu_en = 1'b0; bus_data_ok = 1'($urandom); bus_addr_ok = 1'($urandom);
        #1;
        check("gap_stall", cpu_stall, 1'b0);
        check("gap_req", bus_req, 1'b0);
        cyc();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles spent waiting in ADDR plus DATA before a request is aborted; SHALL be at least 2.
REQ-004 Port clka, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Core-side ports, one per line:
- cpu_en, input, 1: memory access requested this cycle.
- cpu_wmask, input, DATA_W/8: byte write mask; all-zero means read.
- cpu_addr, input, ADDR_W: access address.
- cpu_wdata, input, DATA_W: store data.
- cpu_rdata, output, DATA_W: load data.
- cpu_stall, output, 1: holds the core pipeline.
- cpu_err, output, 1: one-cycle timeout flag.
REQ-007 Bus-side ports, one per line:
- bus_req, output, 1: request valid.
- bus_wr, output, 1: 1 means write.
- bus_addr, output, ADDR_W: request address.
- bus_wstrb, output, DATA_W/8: byte strobes.
- bus_wdata, output, DATA_W: write data.
- bus_addr_ok, input, 1: address accepted.
- bus_data_ok, input, 1: transfer complete.
- bus_rdata, input, DATA_W: read data.

Function
REQ-008 The FSM SHALL have four states: IDLE, ADDR, DATA and DONE.
REQ-009 In IDLE with cpu_en=1, the block SHALL register cpu_addr, cpu_wmask and cpu_wdata, set bus_wr to the OR-reduction of cpu_wmask, and enter ADDR on the next edge.
REQ-010 In IDLE with cpu_en=0, the block SHALL remain in IDLE.
REQ-011 bus_req SHALL be 1 only in ADDR; bus_addr, bus_wstrb, bus_wdata and bus_wr SHALL come from the registered request and stay stable while bus_req=1.
REQ-012 In ADDR with bus_addr_ok=1 and bus_data_ok=0, the FSM SHALL go to DATA.
REQ-013 In ADDR with bus_addr_ok=1 and bus_data_ok=1 in the same cycle, the FSM SHALL go directly to DONE and capture bus_rdata.
REQ-014 In ADDR, bus_data_ok=1 without bus_addr_ok=1 SHALL be ignored.
REQ-015 In DATA with bus_data_ok=1, the FSM SHALL capture bus_rdata into the rdata register (reads only; writes leave it unchanged) and go to DONE.
REQ-016 In DONE, the FSM SHALL return to IDLE unconditionally after one cycle.
REQ-017 cpu_rdata SHALL be driven from the rdata register and hold its value until the next capture.
REQ-018 cpu_stall SHALL be combinational: 1 when (state==IDLE and cpu_en=1) or state is ADDR or DATA; 0 in DONE and when IDLE with cpu_en=0.
REQ-019 Minimum read latency, with bus_addr_ok and bus_data_ok both 1 in the first ADDR cycle: request seen in IDLE at cycle N, ADDR at N+1, DONE at N+2 with cpu_stall=0 and cpu_rdata valid.
REQ-020 A timeout counter, clog2(TIMEOUT)+1 bits wide, SHALL clear on entry to ADDR and increment every cycle spent in ADDR or DATA.
REQ-021 When the counter equals TIMEOUT-1 and the completing handshake is absent that cycle, the FSM SHALL go to DONE, load 0 into the rdata register, and assert cpu_err for exactly the DONE cycle.
REQ-022 A handshake arriving in the same cycle as the timeout SHALL take priority, and the request completes normally.
REQ-023 bus_data_ok pulses received in IDLE or DONE SHALL be ignored.
REQ-024 Only one request SHALL be outstanding at a time.

Reset
REQ-025 While rst=0, the block SHALL asynchronously force: state=IDLE, counter=0, rdata register=0, all registered request fields=0; as a result bus_req=0, bus_wr=0, cpu_err=0 and cpu_rdata=0.
REQ-026 Reset asserted in ADDR or DATA SHALL abandon the transfer, with bus_req=0 immediately.
REQ-027 Bus responses arriving after reset is released SHALL be ignored while in IDLE.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Read at 0x100, addr_ok and data_ok together in the first ADDR cycle, rdata=0xDEADBEEF -> cpu_stall high for 2 cycles, cpu_rdata=0xDEADBEEF in the DONE cycle, cpu_err=0.
- Write at 0x104, wmask=4'b0011, wdata=0x12345678, addr_ok at +1, data_ok at +3 -> bus_wr=1, bus_wstrb=0011, bus_req high exactly 1 cycle, cpu_stall high 4 cycles, cpu_rdata unchanged.
- Read with no bus response, TIMEOUT=16 -> DONE reached 16 cycles after ADDR entry, cpu_err=1 for one cycle, cpu_rdata=0.
- data_ok arriving on the cycle the counter reaches TIMEOUT-1 -> normal completion, cpu_err=0, data captured.
- rst driven low mid-DATA -> bus_req=0 and cpu_rdata=0 without waiting for a clock edge; a late data_ok after release leaves the FSM in IDLE.
- Back-to-back reads: a second cpu_en in the cycle after DONE -> a new ADDR phase with the new address, and no data from the first read leaks into the second.
